// File: rtl/mio_cli_st_pkg.sv
// Shared types and default widths for the mio_cli_st responder slice.
// The response entry width follows DEFAULT_DATA_W; a top-level DATA_W
// override must be matched by the package width.
package mio_cli_st_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 8;

  // One queued response: read data (0 for writes) and error flag.
  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] rdata;
    logic                      err;
  } rsp_entry_t;

endpackage

// File: rtl/mio_cli_st_rsp_fifo.sv
// Response queue for mio_cli_st_responder: power-of-2 circular buffer
// with occupancy count; pointers wrap naturally at DEPTH.
module mio_cli_st_rsp_fifo
  import mio_cli_st_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  rsp_entry_t             push_data,
  input  logic                   pop,
  output rsp_entry_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  rsp_entry_t       mem_q [DEPTH];

  // Next pointer and occupancy; push and pop together keep count unchanged.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // so no path leaves a signal unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; stale entries are never
    // visible because consumers gate the head with the empty flag.
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mio_cli_st_responder.sv
// Register-file responder: accepts read/write requests, answers each with
// one queued response, counts completed response handshakes (saturating).
// Optional macro MIO_CLI_ST_RESPONDER_ADDR_CHK_EN flags out-of-range
// addresses as errors; without it addresses alias modulo NUM_REGS.
module mio_cli_st_responder
  import mio_cli_st_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int NUM_REGS   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       txn_cnt
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [15:0]       txn_cnt_q, txn_cnt_d;
  logic              ready_en_q, ready_en_d;

  logic                        accept;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  rsp_entry_t                  push_entry;
  rsp_entry_t                  head_entry;
  int                          idx;
  logic                        addr_err;

  // Handshakes; req_ready depends only on registered state.
  assign req_ready = ready_en_q && (fifo_count < ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign fifo_push = accept && !fifo_full;
  assign rsp_valid = !fifo_empty;
  assign fifo_pop  = rsp_valid && rsp_ready;

  // Address decode, register update, response build and counter update.
  always_comb begin
`ifdef MIO_CLI_ST_RESPONDER_ADDR_CHK_EN
    addr_err = (int'(req_addr) >= NUM_REGS);
    idx      = addr_err ? 0 : int'(req_addr);
`else
    addr_err = 1'b0;
    idx      = int'(req_addr) % NUM_REGS;
`endif
    regs_d = regs_q;
    if (accept && req_we && !addr_err) regs_d[idx] = req_wdata;

    // Reads capture the pre-edge register value; writes and errors return 0.
    push_entry.err   = addr_err;
    push_entry.rdata = (req_we || addr_err) ? '0 : regs_q[idx];

    txn_cnt_d = txn_cnt_q;
    if (fifo_pop && (txn_cnt_q != 16'hFFFF)) txn_cnt_d = txn_cnt_q + 16'd1;

    // Ready is enabled from the first edge after reset release.
    ready_en_d = 1'b1;
  end

  // Register file, counter and ready-enable state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      txn_cnt_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      txn_cnt_q  <= txn_cnt_d;
      ready_en_q <= ready_en_d;
    end
  end

  mio_cli_st_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Payload is forced to 0 whenever nothing is queued (including reset).
  assign rsp_rdata = fifo_empty ? '0 : head_entry.rdata;
  assign rsp_err   = !fifo_empty && head_entry.err;
  assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_mio_cli_st_responder.sv
// Directed self-checking bench for mio_cli_st_responder (default params).
module tb_mio_cli_st_responder;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] txn_cnt;

  int total = 0;
  int bad   = 0;

  mio_cli_st_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .txn_cnt   (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_txn_cnt",   32'(txn_cnt),   32'd0);
    #19 reset_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(req_ready), 32'd0);
    tick();
    check("ready_after_edge", 32'(req_ready), 32'd1);

    // Write then read, same address on consecutive cycles
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd3; req_wdata = 32'hA5A5_0001;
    tick();
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_rsp_err",   32'(rsp_err), 32'd0);
    req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    check("rd_rsp_err",   32'(rsp_err), 32'd0);
    tick();
    check("rd_drained",   32'(rsp_valid), 32'd0);
    check("rd_txn_cnt",   32'(txn_cnt), 32'd2);

    // Preload regs 5..9 with distinct data, streaming with rsp_ready=1
    req_valid = 1'b1; req_we = 1'b1;
    for (int i = 5; i <= 9; i++) begin
      req_addr  = 8'(i);
      req_wdata = 32'h1000_0000 + 32'(i);
      tick();
    end
    req_valid = 1'b0;
    tick();
    check("preload_txn_cnt", 32'(txn_cnt), 32'd7);
    check("preload_drained", 32'(rsp_valid), 32'd0);

    // Backpressure: 5 reads with rsp_ready=0, only 4 accepted
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_addr = 8'(5 + k);
      check($sformatf("bp_ready_%0d", k), 32'(req_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("bp_full_ready", 32'(req_ready), 32'd0);
    check("bp_head0", rsp_rdata, 32'h1000_0005);
    rsp_ready = 1'b1;
    tick();
    check("bp_ready_back", 32'(req_ready), 32'd1);
    check("bp_head1", rsp_rdata, 32'h1000_0006);
    tick();
    req_valid = 1'b0;
    check("bp_head2", rsp_rdata, 32'h1000_0007);
    tick();
    check("bp_head3", rsp_rdata, 32'h1000_0008);
    tick();
    check("bp_fifth", rsp_rdata, 32'h1000_0009);
    tick();
    check("bp_drained", 32'(rsp_valid), 32'd0);
    check("bp_txn_cnt", 32'(txn_cnt), 32'd12);

    // Full FIFO with a single-cycle pop
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_addr = 8'(5 + k);
      tick();
    end
    req_addr  = 8'd9;
    rsp_ready = 1'b1;
    check("fp_ready_pop_cycle", 32'(req_ready), 32'd0);
    check("fp_valid_pop_cycle", 32'(rsp_valid), 32'd1);
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("fp_ready_next", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    check("fp_occ_head0", rsp_rdata, 32'h1000_0006);
    tick();
    check("fp_occ_head1", rsp_rdata, 32'h1000_0007);
    tick();
    check("fp_occ_head2", rsp_rdata, 32'h1000_0008);
    tick();
    check("fp_occ_empty", 32'(rsp_valid), 32'd0);
    check("fp_txn_cnt",   32'(txn_cnt), 32'd16);

    // Address 20 with NUM_REGS=16
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd4; req_wdata = 32'h0000_0444;
    tick();
    req_we = 1'b0; req_addr = 8'd20;
    tick();
    req_valid = 1'b0;
    check("ae_valid", 32'(rsp_valid), 32'd1);
`ifdef MIO_CLI_ST_RESPONDER_ADDR_CHK_EN
    check("ae_rdata", rsp_rdata, 32'd0);
    check("ae_err",   32'(rsp_err), 32'd1);
    tick();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd20; req_wdata = 32'h0000_DEAD;
    tick();
    req_valid = 1'b0;
    check("ae_wr_err", 32'(rsp_err), 32'd1);
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd4;
    tick();
    req_valid = 1'b0;
    check("ae_reg4_kept", rsp_rdata, 32'h0000_0444);
`else
    check("ae_rdata", rsp_rdata, 32'h0000_0444);
    check("ae_err",   32'(rsp_err), 32'd0);
`endif
    tick();
    check("ae_drained", 32'(rsp_valid), 32'd0);

    // Reset in the middle of queued traffic
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd3;
    repeat (3) tick();
    req_valid = 1'b0;
    check("mr_queued_valid", 32'(rsp_valid), 32'd1);
    check("mr_queued_rdata", rsp_rdata, 32'hA5A5_0001);
    reset_n = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_req_ready", 32'(req_ready), 32'd0);
    check("mr_rsp_rdata", rsp_rdata, 32'd0);
    check("mr_txn_cnt",   32'(txn_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    check("mr_ready_hold", 32'(req_ready), 32'd0);
    tick();
    check("mr_ready_back", 32'(req_ready), 32'd1);
    check("mr_fifo_empty", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd3;
    tick();
    req_valid = 1'b0;
    check("mr_reg3_valid", 32'(rsp_valid), 32'd1);
    check("mr_reg3_zero",  rsp_rdata, 32'd0);
    tick();
    check("mr_txn_one", 32'(txn_cnt), 32'd1);

    // Saturation: more than 65535 handshakes
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd0; rsp_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    req_valid = 1'b0;
    tick();
    tick();
    check("sat_txn_cnt", 32'(txn_cnt), 32'h0000_FFFF);
    check("sat_drained", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
